// File: rtl/ysyx_041461_exe_muldiv_pkg.sv
// Shared definitions for the EXE-stage multiply/divide unit: op codes, FSM encoding
// and a small sign-extension helper.
package ysyx_041461_exe_muldiv_pkg;

    localparam int unsigned MD_OP_W = 4;

    localparam logic [MD_OP_W-1:0] ysyx_041461_MD_MUL    = 4'd0;
    localparam logic [MD_OP_W-1:0] ysyx_041461_MD_MULH   = 4'd1;
    localparam logic [MD_OP_W-1:0] ysyx_041461_MD_MULHSU = 4'd2;
    localparam logic [MD_OP_W-1:0] ysyx_041461_MD_MULHU  = 4'd3;
    localparam logic [MD_OP_W-1:0] ysyx_041461_MD_DIV    = 4'd4;
    localparam logic [MD_OP_W-1:0] ysyx_041461_MD_DIVU   = 4'd5;
    localparam logic [MD_OP_W-1:0] ysyx_041461_MD_REM    = 4'd6;
    localparam logic [MD_OP_W-1:0] ysyx_041461_MD_REMU   = 4'd7;
    localparam logic [MD_OP_W-1:0] ysyx_041461_MD_MULW   = 4'd8;
    localparam logic [MD_OP_W-1:0] ysyx_041461_MD_DIVW   = 4'd9;
    localparam logic [MD_OP_W-1:0] ysyx_041461_MD_DIVUW  = 4'd10;
    localparam logic [MD_OP_W-1:0] ysyx_041461_MD_REMW   = 4'd11;
    localparam logic [MD_OP_W-1:0] ysyx_041461_MD_REMUW  = 4'd12;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_MUL  = 2'd1,
        MD_DIV  = 2'd2,
        MD_DONE = 2'd3
    } md_state_e;

    function automatic logic [63:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

endpackage

// File: rtl/ysyx_041461_exe_muldiv_if.sv
// Operand/result handshake between the EXE pipeline register and the mul/div unit.
// master = pipeline side, slave = the unit.
interface ysyx_041461_exe_muldiv_if #(
    parameter int XLEN = 64
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      in_op;
    logic [XLEN-1:0] in_src1;
    logic [XLEN-1:0] in_src2;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_result;
    logic            stall_req;

    modport master (
        output flush, in_valid, in_op, in_src1, in_src2, out_ready,
        input  in_ready, out_valid, out_result, stall_req
    );

    modport slave (
        input  flush, in_valid, in_op, in_src1, in_src2, out_ready,
        output in_ready, out_valid, out_result, stall_req
    );
endinterface

// File: rtl/ysyx_041461_exe_muldiv_divcore.sv
// Restoring unsigned divider core: one quotient bit per step on 64-bit magnitudes.
// Latency: one bit per step, the owner sequences load/step; step outputs are combinational.
// No backpressure: load wins over step, both are plain enables.
module ysyx_041461_EXE_divcore (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        step,
    input  logic [63:0] dividend,
    input  logic [63:0] divisor,
    output logic [63:0] quo_nxt,
    output logic [63:0] rem_nxt
);
    logic [63:0] quo_q, quo_d;
    logic [63:0] rem_q, rem_d;
    logic [63:0] dsr_q, dsr_d;
    logic [64:0] rem_sh;
    logic [64:0] rem_sub;
    logic        fits;

    // The partial remainder stays below the divisor, so the trial subtract's bit 64 is a pure borrow.
    always_comb begin
        rem_sh  = {rem_q, quo_q[63]};
        rem_sub = rem_sh - {1'b0, dsr_q};
        fits    = ~rem_sub[64];
        quo_nxt = {quo_q[62:0], fits};
        rem_nxt = fits ? rem_sub[63:0] : rem_sh[63:0];
    end

    always_comb begin
        quo_d = quo_q;
        rem_d = rem_q;
        dsr_d = dsr_q;
        if (load) begin
            quo_d = dividend;
            rem_d = '0;
            dsr_d = divisor;
        end else if (step) begin
            quo_d = quo_nxt;
            rem_d = rem_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            quo_q <= '0;
            rem_q <= '0;
            dsr_q <= '0;
        end else begin
            quo_q <= quo_d;
            rem_q <= rem_d;
            dsr_q <= dsr_d;
        end
    end
endmodule

// File: rtl/ysyx_041461_exe_muldiv.sv
// Iterative RV64M multiply/divide unit for the EXE stage.
// Latency: N edges after accept (N=64, or 32 for W ops); special cases complete on the accept edge.
// Backpressure: result held in DONE until out_ready; stall_req freezes upstream meanwhile.
module ysyx_041461_exe_muldiv
    import ysyx_041461_exe_muldiv_pkg::*;
#(
    parameter int XLEN = 64
) (
    input logic                      clk,
    input logic                      rst,
    ysyx_041461_exe_muldiv_if.slave  md
);
    md_state_e       state_q, state_d;
    logic [6:0]      cnt_q, cnt_d;
    logic [3:0]      op_q, op_d;
    logic            negp_q, negp_d;
    logic            negq_q, negq_d;
    logic            negr_q, negr_d;
    logic [127:0]    mcand_q, mcand_d;
    logic [63:0]     mplr_q, mplr_d;
    logic [127:0]    prod_q, prod_d;
    logic [XLEN-1:0] res_q, res_d;

    logic            is_w, is_mul, is_div, is_quo, s1_sgn, s2_sgn;
    logic            neg1, neg2, div_zero, div_ovf, special;
    logic [63:0]     a_ext, b_ext, mag1, mag2, w_min, spec_res;

    logic [127:0]    prod_step, prod_fix;
    logic [63:0]     quo_nxt, rem_nxt, quo_fix, rem_fix;
    logic [63:0]     mul_res, div_res;
    logic            div_load, div_step;

    always_comb begin
        is_w   = md.in_op inside {ysyx_041461_MD_MULW, ysyx_041461_MD_DIVW, ysyx_041461_MD_DIVUW,
                                  ysyx_041461_MD_REMW, ysyx_041461_MD_REMUW};
        is_mul = md.in_op inside {ysyx_041461_MD_MUL, ysyx_041461_MD_MULH, ysyx_041461_MD_MULHSU,
                                  ysyx_041461_MD_MULHU, ysyx_041461_MD_MULW};
        is_div = md.in_op inside {ysyx_041461_MD_DIV, ysyx_041461_MD_DIVU, ysyx_041461_MD_REM,
                                  ysyx_041461_MD_REMU, ysyx_041461_MD_DIVW, ysyx_041461_MD_DIVUW,
                                  ysyx_041461_MD_REMW, ysyx_041461_MD_REMUW};
        is_quo = md.in_op inside {ysyx_041461_MD_DIV, ysyx_041461_MD_DIVU,
                                  ysyx_041461_MD_DIVW, ysyx_041461_MD_DIVUW};
        s1_sgn = md.in_op inside {ysyx_041461_MD_MULH, ysyx_041461_MD_MULHSU, ysyx_041461_MD_DIV,
                                  ysyx_041461_MD_REM, ysyx_041461_MD_DIVW, ysyx_041461_MD_REMW};
        s2_sgn = md.in_op inside {ysyx_041461_MD_MULH, ysyx_041461_MD_DIV, ysyx_041461_MD_REM,
                                  ysyx_041461_MD_DIVW, ysyx_041461_MD_REMW};

        a_ext = md.in_src1;
        b_ext = md.in_src2;
        if (is_w) begin
            a_ext = s1_sgn ? sext32(md.in_src1[31:0]) : {32'd0, md.in_src1[31:0]};
            b_ext = s2_sgn ? sext32(md.in_src2[31:0]) : {32'd0, md.in_src2[31:0]};
        end

        // The magnitude of the most negative value is 2^63, which still fits unsigned.
        neg1 = s1_sgn & a_ext[63];
        neg2 = s2_sgn & b_ext[63];
        mag1 = neg1 ? -a_ext : a_ext;
        mag2 = neg2 ? -b_ext : b_ext;

        w_min    = is_w ? sext32(32'h8000_0000) : 64'h8000_0000_0000_0000;
        div_zero = is_div & (b_ext == 64'd0);
        div_ovf  = is_div & s2_sgn & (a_ext == w_min) & (b_ext == '1);
        special  = ~(is_mul | is_div) | div_zero | div_ovf;

        spec_res = '0;
        if (div_zero) begin
            if (is_quo)    spec_res = '1;
            else if (is_w) spec_res = sext32(md.in_src1[31:0]);
            else           spec_res = md.in_src1;
        end else if (div_ovf) begin
            spec_res = is_quo ? a_ext : 64'd0;
        end
    end

    ysyx_041461_EXE_divcore u_divcore (
        .clk      (clk),
        .rst      (rst),
        .load     (div_load),
        .step     (div_step),
        .dividend (is_w ? {mag1[31:0], 32'd0} : mag1),
        .divisor  (mag2),
        .quo_nxt  (quo_nxt),
        .rem_nxt  (rem_nxt)
    );

    always_comb begin
        prod_step = mplr_q[0] ? (prod_q + mcand_q) : prod_q;
        prod_fix  = negp_q ? -prod_step : prod_step;
        quo_fix   = negq_q ? -quo_nxt : quo_nxt;
        rem_fix   = negr_q ? -rem_nxt : rem_nxt;

        case (op_q)
            ysyx_041461_MD_MUL:  mul_res = prod_fix[63:0];
            ysyx_041461_MD_MULW: mul_res = sext32(prod_fix[31:0]);
            default:             mul_res = prod_fix[127:64];
        endcase

        case (op_q)
            ysyx_041461_MD_DIV, ysyx_041461_MD_DIVU:   div_res = quo_fix;
            ysyx_041461_MD_REM, ysyx_041461_MD_REMU:   div_res = rem_fix;
            ysyx_041461_MD_DIVW, ysyx_041461_MD_DIVUW: div_res = sext32(quo_fix[31:0]);
            default:                                   div_res = sext32(rem_fix[31:0]);
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        negp_d   = negp_q;
        negq_d   = negq_q;
        negr_d   = negr_q;
        mcand_d  = mcand_q;
        mplr_d   = mplr_q;
        prod_d   = prod_q;
        res_d    = res_q;
        div_load = 1'b0;
        div_step = 1'b0;

        if (md.flush) begin
            state_d = MD_IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                MD_IDLE: begin
                    if (md.in_valid) begin
                        op_d   = md.in_op;
                        negp_d = neg1 ^ neg2;
                        negq_d = neg1 ^ neg2;
                        negr_d = neg1;
                        if (special) begin
                            state_d = MD_DONE;
                            res_d   = spec_res;
                        end else begin
                            cnt_d = is_w ? 7'd32 : 7'd64;
                            if (is_mul) begin
                                state_d = MD_MUL;
                                mcand_d = {64'd0, mag1};
                                mplr_d  = mag2;
                                prod_d  = '0;
                            end else begin
                                state_d  = MD_DIV;
                                div_load = 1'b1;
                            end
                        end
                    end
                end
                MD_MUL: begin
                    prod_d  = prod_step;
                    mcand_d = mcand_q << 1;
                    mplr_d  = mplr_q >> 1;
                    cnt_d   = cnt_q - 7'd1;
                    if (cnt_q == 7'd1) begin
                        state_d = MD_DONE;
                        res_d   = mul_res;
                    end
                end
                MD_DIV: begin
                    div_step = 1'b1;
                    cnt_d    = cnt_q - 7'd1;
                    if (cnt_q == 7'd1) begin
                        state_d = MD_DONE;
                        res_d   = div_res;
                    end
                end
                MD_DONE: begin
                    if (md.out_ready) state_d = MD_IDLE;
                end
                default: state_d = MD_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            negp_q  <= 1'b0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            mcand_q <= '0;
            mplr_q  <= '0;
            prod_q  <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            negp_q  <= negp_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            mcand_q <= mcand_d;
            mplr_q  <= mplr_d;
            prod_q  <= prod_d;
            res_q   <= res_d;
        end
    end

    assign md.in_ready   = (state_q == MD_IDLE);
    assign md.out_valid  = (state_q == MD_DONE);
    assign md.out_result = res_q;
    assign md.stall_req  = md.in_valid & ~md.out_valid;
endmodule

// File: doc/ysyx_041461_exe_muldiv.md
# ysyx_041461_EXE_muldiv

Iterative RV64M multiply/divide unit in the EXE stage, fed by the EXE pipeline register with already-forwarded operands. It accepts one operation at a time and computes it over 32 or 64 cycles with a shared shift datapath. It raises a stall request that freezes the upstream pipeline registers until the result is consumed, and a pipeline flush aborts it.

## Interface
Parameters:
- XLEN, 64, operand and result width; only 64 is supported.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous, active-low.
- flush  in  1  kills any in-flight or completed operation.
- in_valid  in  1  operation present on in_op/in_src1/in_src2.
- in_ready  out  1  combinational; high only in IDLE.
- in_op  in  4  operation code from the shared define header.
- in_src1  in  64  rs1 operand (dividend / multiplicand).
- in_src2  in  64  rs2 operand (divisor / multiplier).
- out_valid  out  1  result valid; high only in DONE.
- out_ready  in  1  downstream consumes the result.
- out_result  out  64  result; holds its value except on a completion edge.
- stall_req  out  1  combinational: in_valid & ~out_valid; drives upstream register enables low.

## Operation
- Op codes: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU, 8 MULW, 9 DIVW, 10 DIVUW, 11 REMW, 12 REMUW. Codes 13–15 are illegal and produce result 0.
- States: IDLE, MUL, DIV, DONE.
- IDLE -> MUL/DIV on accept (in_valid & in_ready). On the same edge the unit latches the operand magnitudes and sign flags, and loads the counter with N: 64, or 32 for W ops.
- Special cases go IDLE -> DONE directly and load the final result:
  - Divide by zero: quotient = all ones; remainder = dividend (sign-extended for W ops).
  - Signed overflow (min / -1): quotient = min; remainder = 0.
  - Illegal codes: result 0.
- MUL state: one shift-add per edge on a 128-bit unsigned product.
- DIV state: one restoring-division step per edge on the unsigned magnitudes.
- Counter decrements each iteration. The edge with counter == 1 applies the sign correction, selects the result, writes out_result and enters DONE.
- Result selection:
  - MUL returns product[63:0]; MULH, MULHSU and MULHU return product[127:64].
  - W ops use src[31:0] and sign-extend result[31:0] to 64 bits.
- Signedness:
  - MULH, DIV, REM, DIVW, REMW: both operands signed.
  - MULHSU: src1 signed, src2 unsigned.
  - MULW: low 32 bits are sign-agnostic.
- Sign correction:
  - Product is negated if exactly one signed operand is negative.
  - Quotient is negated if dividend and divisor signs differ.
  - Remainder takes the dividend's sign.
- DONE -> IDLE on out_ready. No new op is accepted on that edge.
- flush, whenever it is high, forces IDLE on the next edge. It has priority over accept, iteration and completion; out_valid falls and out_result keeps its last value.

## Timing
- Reset values: state IDLE, counter 0, out_valid 0, out_result 0, in_ready 1, stall_req 0. Reset mid-operation discards everything.
- Op accepted at edge t0: out_valid is high after edge t0+N (N = 64 or 32) and after edge t0+1 for special cases.
- Throughput: one op per N+2 cycles minimum (accept, N iterations, retire).
- stall_req stays high from the first cycle in_valid is high until DONE. It is low in DONE, so the upstream register advances on the same edge the result is consumed.
- in_valid falling mid-operation does not abort; only flush or reset aborts.
- If out_ready and flush are both high in DONE, the unit goes to IDLE (same result either way).

## Structure
- Op code defines (ysyx_041461_MD_MUL … ysyx_041461_MD_REMUW) and the state encoding go in the shared define header next to the existing EXE_ctrl codes.
- One sub-module: ysyx_041461_EXE_divcore, holding the restoring divider's remainder/quotient shift registers and the step logic. The multiplier shift-add and the FSM stay in the top.

## Test plan
- Reset low mid-DIV (counter 20) -> IDLE, out_valid 0, out_result 0 immediately; in_ready 1 after release.
- MULH src1=0xFFFF_FFFF_FFFF_FFFF (-1), src2=2 -> out_result 0xFFFF_FFFF_FFFF_FFFF after exactly 64 edges; MULHU with the same operands -> 0x1.
- DIV src1=-7, src2=2 -> quotient 0xFFFF_FFFF_FFFF_FFFD (-3); REM -> 0xFFFF_FFFF_FFFF_FFFF (-1); DIVUW src1=0x1_0000_0009, src2=2 -> 0x4 after 32 edges.
- DIV by 0 with src1=5 -> 0xFFFF_FFFF_FFFF_FFFF after 1 edge; REM by 0 -> 5. DIV 0x8000_0000_0000_0000 / -1 -> 0x8000_0000_0000_0000; REMW 0x8000_0000 / -1 -> 0.
- Back-pressure: hold out_ready=0 for 10 cycles in DONE -> out_valid and out_result stable, stall_req 0, in_ready 0; out_ready=1 -> IDLE on the next edge.
- flush at iteration 30 of MUL -> IDLE next edge, no out_valid pulse; an op accepted next -> correct result, unaffected by the aborted state.
